// File: rtl/pomodoro_pkg.sv
// Shared definitions for the pomodoro session controller: FSM states,
// phase encoding, UART command bytes and the work-length lookup.
package pomodoro_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_WORK  = 3'd1,
        WORK       = 3'd2,
        WORK_P     = 3'd3,
        LOAD_SHORT = 3'd4,
        LOAD_LONG  = 3'd5,
        BRK        = 3'd6,
        BRK_P      = 3'd7
    } state_t;

    localparam logic [1:0] PHASE_IDLE  = 2'd0;
    localparam logic [1:0] PHASE_WORK  = 2'd1;
    localparam logic [1:0] PHASE_SHORT = 2'd2;
    localparam logic [1:0] PHASE_LONG  = 2'd3;

    localparam logic [7:0] CMD_START = 8'h53;
    localparam logic [7:0] CMD_PAUSE = 8'h50;
    localparam logic [7:0] CMD_ABORT = 8'h52;
    localparam logic [7:0] CMD_SEL0  = 8'h30;
    localparam logic [7:0] CMD_SEL1  = 8'h31;
    localparam logic [7:0] CMD_SEL2  = 8'h32;
    localparam logic [7:0] CMD_SEL3  = 8'h33;

    // Work session length in minutes for each work_sel setting.
    function automatic logic [6:0] work_minutes(input logic [1:0] sel);
        logic [6:0] mins;
        case (sel)
            2'd0:    mins = 7'd25;
            2'd1:    mins = 7'd30;
            2'd2:    mins = 7'd45;
            default: mins = 7'd60;
        endcase
        return mins;
    endfunction

endpackage

// File: rtl/pomodoro_cmd_decode.sv
// Turns the UART RX FIFO head byte into one-hot command strobes and pops
// every byte (known or not) in the same cycle it is presented.
module pomodoro_cmd_decode (
    input  logic       pop_en,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    output logic       start,
    output logic       pause,
    output logic       abort,
    output logic       sel_valid,
    output logic [1:0] sel
);
    import pomodoro_pkg::*;

    // Decode the head byte; unknown bytes are still popped but raise nothing.
    always_comb begin
        rd_uart   = pop_en & ~rx_empty;
        start     = 1'b0;
        pause     = 1'b0;
        abort     = 1'b0;
        sel_valid = 1'b0;
        sel       = r_data[1:0];
        if (pop_en && !rx_empty) begin
            case (r_data)
                CMD_START: start = 1'b1;
                CMD_PAUSE: pause = 1'b1;
                CMD_ABORT: abort = 1'b1;
                CMD_SEL0, CMD_SEL1, CMD_SEL2, CMD_SEL3: sel_valid = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pomodoro_sequencer.sv
// Pomodoro session controller: sequences work / short-break / long-break
// phases, loads the countdown timer and gates its run enable.
// Optional macro AUTO_START_EN: when defined, the end of a break starts the
// next work session directly instead of returning to idle.
module pomodoro_sequencer #(
    parameter int SHORT_BREAK_MIN = 5,
    parameter int LONG_BREAK_MIN  = 15,
    parameter int CYCLES_PER_LONG = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    input  logic       pause_pedge,
    input  logic       tmr_done,
    output logic       tmr_load,
    output logic [6:0] tmr_min,
    output logic [6:0] tmr_sec,
    output logic       tmr_run,
    output logic [1:0] phase,
    output logic       paused,
    output logic [2:0] cycle_cnt,
    output logic       alarm
);
    import pomodoro_pkg::*;

    localparam logic [6:0] SHORT_MIN   = 7'(SHORT_BREAK_MIN);
    localparam logic [6:0] LONG_MIN    = 7'(LONG_BREAK_MIN);
    localparam logic [2:0] LONG_CYCLES = 3'(CYCLES_PER_LONG);

    logic       cmd_start;
    logic       cmd_pause;
    logic       cmd_abort;
    logic       cmd_sel_valid;
    logic [1:0] cmd_sel;
    logic       pause_any;

    state_t     state;
    state_t     state_next;
    logic [1:0] work_sel;
    logic [1:0] work_sel_next;
    logic [2:0] cnt;
    logic [2:0] cnt_next;
    logic [2:0] cnt_inc;
    logic       long_brk;
    logic       long_brk_next;
    logic [6:0] min_q;
    logic [6:0] min_next;
    logic       alarm_q;
    logic       alarm_next;

    pomodoro_cmd_decode u_decode (
        .pop_en    (reset_n),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd_uart   (rd_uart),
        .start     (cmd_start),
        .pause     (cmd_pause),
        .abort     (cmd_abort),
        .sel_valid (cmd_sel_valid),
        .sel       (cmd_sel)
    );

    // A 'P' byte and a button edge in the same cycle merge into one toggle.
    assign pause_any = cmd_pause | pause_pedge;
    assign cnt_inc   = (cnt < LONG_CYCLES) ? cnt + 3'd1 : cnt;

    // Next-state logic with priority abort > tmr_done > pause.
    always_comb begin
        state_next    = state;
        work_sel_next = cmd_sel_valid ? cmd_sel : work_sel;
        cnt_next      = cnt;
        long_brk_next = long_brk;
        min_next      = min_q;
        alarm_next    = 1'b0;
        if (cmd_abort) begin
            state_next = IDLE;
            cnt_next   = 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_start || pause_any) begin
                        state_next = LOAD_WORK;
                        min_next   = work_minutes(work_sel_next);
                    end
                end
                LOAD_WORK: state_next = WORK;
                WORK: begin
                    if (tmr_done) begin
                        alarm_next = 1'b1;
                        cnt_next   = cnt_inc;
                        if (cnt_inc == LONG_CYCLES) begin
                            state_next    = LOAD_LONG;
                            min_next      = LONG_MIN;
                            long_brk_next = 1'b1;
                        end else begin
                            state_next    = LOAD_SHORT;
                            min_next      = SHORT_MIN;
                            long_brk_next = 1'b0;
                        end
                    end else if (pause_any) begin
                        state_next = WORK_P;
                    end
                end
                WORK_P: begin
                    if (pause_any) state_next = WORK;
                end
                LOAD_SHORT: state_next = BRK;
                LOAD_LONG: begin
                    state_next = BRK;
                    cnt_next   = 3'd0;
                end
                BRK: begin
                    if (tmr_done) begin
                        alarm_next = 1'b1;
`ifdef AUTO_START_EN
                        state_next = LOAD_WORK;
                        min_next   = work_minutes(work_sel_next);
`else
                        state_next = IDLE;
`endif
                    end else if (pause_any) begin
                        state_next = BRK_P;
                    end
                end
                BRK_P: begin
                    if (pause_any) state_next = BRK;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            work_sel <= 2'd0;
            cnt      <= 3'd0;
            long_brk <= 1'b0;
            min_q    <= 7'd0;
            alarm_q  <= 1'b0;
        end else begin
            state    <= state_next;
            work_sel <= work_sel_next;
            cnt      <= cnt_next;
            long_brk <= long_brk_next;
            min_q    <= min_next;
            alarm_q  <= alarm_next;
        end
    end

    // Phase report derived from the state and the break type.
    always_comb begin
        case (state)
            LOAD_WORK, WORK, WORK_P: phase = PHASE_WORK;
            LOAD_SHORT:              phase = PHASE_SHORT;
            LOAD_LONG:               phase = PHASE_LONG;
            BRK, BRK_P:              phase = long_brk ? PHASE_LONG : PHASE_SHORT;
            default:                 phase = PHASE_IDLE;
        endcase
    end

    assign tmr_load  = (state == LOAD_WORK) || (state == LOAD_SHORT) || (state == LOAD_LONG);
    assign tmr_run   = (state == WORK) || (state == BRK);
    assign paused    = (state == WORK_P) || (state == BRK_P);
    assign tmr_min   = min_q;
    assign tmr_sec   = 7'd0;
    assign cycle_cnt = cnt;
    assign alarm     = alarm_q;

endmodule

// File: tb/tb_pomodoro_sequencer.sv
// Self-checking bench for pomodoro_sequencer: directed session scenarios
// followed by random command/button/timer traffic, all compared against a
// phase-level behavioural model. Honours AUTO_START_EN like the design.
module tb_pomodoro_sequencer;

    localparam int SHORT_MIN = 5;
    localparam int LONG_MIN  = 15;
    localparam int CYCLES    = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       pause_pedge;
    logic       tmr_done;
    logic       tmr_load;
    logic [6:0] tmr_min;
    logic [6:0] tmr_sec;
    logic       tmr_run;
    logic [1:0] phase;
    logic       paused;
    logic [2:0] cycle_cnt;
    logic       alarm;

    int check_count = 0;
    int pass_count  = 0;

    int m_phase;
    int m_cnt;
    int m_sel;
    int m_min;
    bit m_loading;
    bit m_paused;
    bit m_alarm;
    int work_len[4] = '{25, 30, 45, 60};

    pomodoro_sequencer #(
        .SHORT_BREAK_MIN (SHORT_MIN),
        .LONG_BREAK_MIN  (LONG_MIN),
        .CYCLES_PER_LONG (CYCLES)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_empty    (rx_empty),
        .r_data      (r_data),
        .rd_uart     (rd_uart),
        .pause_pedge (pause_pedge),
        .tmr_done    (tmr_done),
        .tmr_load    (tmr_load),
        .tmr_min     (tmr_min),
        .tmr_sec     (tmr_sec),
        .tmr_run     (tmr_run),
        .phase       (phase),
        .paused      (paused),
        .cycle_cnt   (cycle_cnt),
        .alarm       (alarm)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int unsigned actual, input int unsigned expected);
        check_count++;
        if (actual == expected) pass_count++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    endtask

    // Phase-level model: one step per clock edge given that cycle's inputs.
    task automatic modelStep(input bit empty, input logic [7:0] data, input bit pp, input bit done);
        bit is_start;
        bit is_pause;
        bit is_abort;
        int new_sel;
        is_start = !empty && data == 8'h53;
        is_pause = (!empty && data == 8'h50) || pp;
        is_abort = !empty && data == 8'h52;
        new_sel  = (!empty && data >= 8'h30 && data <= 8'h33) ? int'(data) - 8'h30 : m_sel;
        m_alarm  = 1'b0;
        if (is_abort) begin
            m_phase = 0; m_loading = 0; m_paused = 0; m_cnt = 0;
        end else if (m_phase == 0) begin
            if (is_start || is_pause) begin
                m_phase = 1; m_loading = 1; m_min = work_len[new_sel];
            end
        end else if (m_loading) begin
            m_loading = 0;
            if (m_phase == 3) m_cnt = 0;
        end else if (m_paused) begin
            if (is_pause) m_paused = 0;
        end else if (done) begin
            m_alarm = 1;
            if (m_phase == 1) begin
                m_cnt = (m_cnt + 1 > CYCLES) ? CYCLES : m_cnt + 1;
                m_loading = 1;
                if (m_cnt == CYCLES) begin m_phase = 3; m_min = LONG_MIN; end
                else begin m_phase = 2; m_min = SHORT_MIN; end
            end else begin
`ifdef AUTO_START_EN
                m_phase = 1; m_loading = 1; m_min = work_len[new_sel];
`else
                m_phase = 0;
`endif
            end
        end else if (is_pause) begin
            m_paused = 1;
        end
        m_sel = new_sel;
    endtask

    task automatic compareAll();
        checkOutput("phase", phase, m_phase);
        checkOutput("tmr_load", tmr_load, m_loading);
        checkOutput("tmr_min", tmr_min, m_min);
        checkOutput("tmr_sec", tmr_sec, 0);
        checkOutput("tmr_run", tmr_run, (m_phase != 0 && !m_loading && !m_paused) ? 1 : 0);
        checkOutput("paused", paused, m_paused);
        checkOutput("cycle_cnt", cycle_cnt, m_cnt);
        checkOutput("alarm", alarm, m_alarm);
    endtask

    task automatic applyStimulus(input bit empty, input logic [7:0] data, input bit pp, input bit done);
        @(negedge clk);
        rx_empty    = empty;
        r_data      = data;
        pause_pedge = pp;
        tmr_done    = done;
        #1;
        checkOutput("rd_uart", rd_uart, !empty);
        modelStep(empty, data, pp, done);
        @(posedge clk);
        #1;
        compareAll();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    endtask

    // Directed scenarios followed by random traffic.
    initial begin
        logic [7:0] byte_set[9];
        byte_set = '{8'h53, 8'h50, 8'h52, 8'h30, 8'h31, 8'h32, 8'h33, 8'h41, 8'hFF};

        m_phase = 0; m_cnt = 0; m_sel = 0; m_min = 0;
        m_loading = 0; m_paused = 0; m_alarm = 0;

        reset_n     = 1'b0;
        rx_empty    = 1'b0;
        r_data      = 8'h53;
        pause_pedge = 1'b0;
        tmr_done    = 1'b0;
        #12;
        checkOutput("rst_rd_uart", rd_uart, 0);
        checkOutput("rst_phase", phase, 0);
        checkOutput("rst_tmr_load", tmr_load, 0);
        checkOutput("rst_tmr_min", tmr_min, 0);
        checkOutput("rst_tmr_sec", tmr_sec, 0);
        checkOutput("rst_tmr_run", tmr_run, 0);
        checkOutput("rst_paused", paused, 0);
        checkOutput("rst_cycle_cnt", cycle_cnt, 0);
        checkOutput("rst_alarm", alarm, 0);
        rx_empty = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        idleCycles(2);

        // Select 45 minutes and start.
        applyStimulus(1'b0, 8'h32, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h53, 1'b0, 1'b0);
        checkOutput("start_load", tmr_load, 1);
        checkOutput("start_min", tmr_min, 45);
        idleCycles(3);

        // Pause by button, resume by byte.
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
        idleCycles(2);
        applyStimulus(1'b0, 8'h50, 1'b0, 1'b0);
        idleCycles(2);

        // Four work/break rounds; the fourth break is long.
        for (int r = 0; r < 4; r++) begin
            applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
            idleCycles(3);
            applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
            idleCycles(1);
            applyStimulus(1'b0, 8'h53, 1'b0, 1'b0);
            idleCycles(3);
        end

        // tmr_done and abort together: abort wins.
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
        idleCycles(2);
        applyStimulus(1'b0, 8'h52, 1'b0, 1'b1);
        checkOutput("abort_alarm", alarm, 0);
        checkOutput("abort_phase", phase, 0);
        idleCycles(2);

        // Byte pause and button pause together during a short break.
        applyStimulus(1'b0, 8'h53, 1'b0, 1'b0);
        idleCycles(3);
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
        idleCycles(2);
        applyStimulus(1'b0, 8'h50, 1'b1, 1'b0);
        checkOutput("dual_pause", paused, 1);
        idleCycles(2);
        applyStimulus(1'b0, 8'h50, 1'b0, 1'b0);
        idleCycles(2);
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
        idleCycles(3);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            int pick;
            bit empty;
            pick  = $urandom_range(0, 16);
            empty = ($urandom_range(0, 9) < 7);
            applyStimulus(empty,
                          (pick < 4) ? byte_set[0] :
                          (pick < 8) ? byte_set[1] :
                          (pick == 8) ? ((i % 3 == 0) ? byte_set[2] : byte_set[7]) :
                          (pick < 13) ? byte_set[pick - 6] : byte_set[8],
                          ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 9) == 0));
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/pomodoro_sequencer.md
Name: pomodoro_sequencer

Overview:
Session controller for the pomodoro timer datapath. It consumes command bytes from the UART RX FIFO and pause-button edges, then sequences work / short-break / long-break phases. For each phase it loads start values into the countdown timer, gates the timer's run enable and counts completed work sessions. It sits between the uart / button front end and the countdown timer, replacing the ad-hoc sel decode and the free-running break trigger.

Parameters:
SHORT_BREAK_MIN, 5, short-break length in minutes (1..99)
LONG_BREAK_MIN, 15, long-break length in minutes (1..99)
CYCLES_PER_LONG, 4, work sessions per long break (1..7)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
rx_empty  in  1  UART RX FIFO empty
r_data  in  8  UART RX FIFO head byte; valid while rx_empty=0
rd_uart  out  1  FIFO pop strobe, 1 cycle
pause_pedge  in  1  debounced pause-button rising edge, 1 cycle
tmr_done  in  1  countdown reached 00:00, 1-cycle pulse
tmr_load  out  1  load strobe to timer, 1 cycle
tmr_min  out  7  minutes load value, valid with tmr_load
tmr_sec  out  7  seconds load value, always 0
tmr_run  out  1  timer count enable (level)
phase  out  2  0 idle, 1 work, 2 short break, 3 long break
paused  out  1  current phase frozen
cycle_cnt  out  3  completed work sessions since last long break
alarm  out  1  1-cycle pulse at every phase end

Behaviour:
- Reset (asynchronous, reset_n=0): all outputs 0; state IDLE; work_sel=0.
- Command fetch:
  - In any state, when rx_empty=0: decode r_data and pulse rd_uart in the same cycle.
  - At most one byte is consumed per cycle.
  - Unknown bytes are popped and ignored.
- Commands:
  - 'S' (0x53): start. Acts only in IDLE.
  - 'P' (0x50): pause toggle. Equivalent to pause_pedge.
  - 'R' (0x52): abort. From any state go to IDLE; cycle_cnt cleared; tmr_run=0.
  - '0'..'3' (0x30..0x33): set work_sel. Takes effect at the next LOAD_WORK; never alters a running phase.
- Work length by work_sel: 0→25, 1→30, 2→45, 3→60 minutes.
- States:
  - IDLE: tmr_run=0, phase=0. 'S' or pause_pedge → LOAD_WORK.
  - LOAD_WORK: tmr_load=1, tmr_min=work length, phase=1 → WORK (1 cycle).
  - WORK: tmr_run=1.
    - pause → WORK_P.
    - tmr_done → alarm=1; cycle_cnt+1; then:
      - if the new count equals CYCLES_PER_LONG → LOAD_LONG;
      - otherwise → LOAD_SHORT.
  - WORK_P: tmr_run=0, paused=1. pause → WORK (the timer keeps its value, no reload).
  - LOAD_SHORT / LOAD_LONG:
    - tmr_load=1 with the matching break minutes.
    - phase=2 or 3 respectively.
    - LOAD_LONG also clears cycle_cnt.
    - → BRK.
  - BRK: tmr_run=1. pause → BRK_P. tmr_done → alarm=1 → IDLE.
  - BRK_P: as WORK_P, returning to BRK.
- Latency:
  - 'S' accepted at edge N → tmr_load high during cycle N+1 → tmr_run high from cycle N+2.
  - tmr_done at edge N → alarm and the state change occur on the same edge N.
- Priority within a single cycle: 'R' > tmr_done > pause (byte or button).
  - 'P' byte and pause_pedge in the same cycle count as one toggle.
  - tmr_done while paused is ignored (cannot occur with a gated timer).
- tmr_done in IDLE or LOAD_* is ignored.
- cycle_cnt saturates logic: it never exceeds CYCLES_PER_LONG; wrap is via the LOAD_LONG clear.
- tmr_sec is hard-wired 0. tmr_min is held at its last load value between loads.

Optional Feature:
AUTO_START_EN
- Defined: BRK tmr_done → LOAD_WORK directly (continuous cycling); alarm still pulses.
- Undefined: BRK tmr_done → IDLE, waiting for 'S' or pause_pedge.

Decomposition:
- Package pomodoro_pkg holds:
  - state enum (IDLE, LOAD_WORK, WORK, WORK_P, LOAD_SHORT, LOAD_LONG, BRK, BRK_P);
  - phase encoding constants;
  - command byte constants (CMD_START, CMD_PAUSE, CMD_ABORT, CMD_SEL0..3);
  - the work-length lookup function.
- One sub-module, pomodoro_cmd_decode: combinational byte → one-hot command {start, pause, abort, sel_valid, sel[1:0]} plus rd_uart gating.

Test Plan:
- Reset, then push '2','S' into FIFO → two rd_uart pulses; tmr_load with tmr_min=45; phase=1; tmr_run=1 two cycles after the 'S' pop.
- In WORK, pause_pedge; later 'P' byte → paused=1/tmr_run=0, then paused=0/tmr_run=1; no second tmr_load.
- Four work/break rounds with tmr_done pulses → breaks 1-3 load 5 min (phase=2); the 4th loads 15 (phase=3) and cycle_cnt returns to 0.
- tmr_done and 'R' byte in the same cycle → state IDLE, cycle_cnt=0, no tmr_load next cycle, alarm=0.
- 'P' byte and pause_pedge in the same cycle during BRK → single toggle to BRK_P; byte popped.
- Short break ends → with AUTO_START_EN: tmr_load with work length on the next cycle; without it: phase=0, tmr_run=0.
